// File: rtl/mdio_receptor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mdio_receptor
//  Brief    : Clause 22 MDIO frame receiver (PHY side), clocked by MDC.
//  Revision : 1.0
// ============================================================================
module mdio_receptor (
  input  logic        MDC,
  input  logic        RESET,
  input  logic [31:0] MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        MDIO_DONE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_WR_BODY = 3'd2,
    S_RD_TA   = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_WR       = 2'b01;
  localparam logic [4:0] c_CNT_ST      = 5'd1;   // edge 2 being sampled
  localparam logic [4:0] c_CNT_OP      = 5'd3;   // edge 4
  localparam logic [4:0] c_CNT_HDR_END = 5'd13;  // edge 14
  localparam logic [4:0] c_CNT_TA_END  = 5'd15;  // edge 16
  localparam logic [4:0] c_CNT_LAST    = 5'd31;  // edge 32

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_shift;
  logic [15:0] r_tx;
  logic        w_bit;
  logic        w_shift_en, w_addr_ld, w_wr_ld, w_done;
  logic        w_tx_ld, w_tx_sh, w_tx_clr;
  logic        w_unused;

  assign w_bit    = MDIO_OUT[0];
  assign w_unused = ^MDIO_OUT[31:1];

  // r_cnt holds the number of the previous frame edge, so edge N sees N-1.
  always_ff @(posedge MDC) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 5'd1;
    w_shift_en  = 1'b0;
    w_addr_ld   = 1'b0;
    w_wr_ld     = 1'b0;
    w_done      = 1'b0;
    w_tx_ld     = 1'b0;
    w_tx_sh     = 1'b0;
    w_tx_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 5'd0;
        if (MDIO_OE && !w_bit) begin
          w_state_nxt = S_HEADER;
          w_cnt_nxt   = 5'd1;
          w_shift_en  = 1'b1;
        end
      end
      S_HEADER: begin
        w_shift_en = 1'b1;
        if (!MDIO_OE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end else if (r_cnt == c_CNT_ST && !w_bit) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end else if (r_cnt == c_CNT_OP && (r_shift[0] == w_bit)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end else if (r_cnt == c_CNT_HDR_END) begin
          // OP bits arrived on edges 3 and 4, now 10 and 9 places back
          w_addr_ld   = 1'b1;
          w_state_nxt = (r_shift[10:9] == c_OP_WR) ? S_WR_BODY : S_RD_TA;
        end
      end
      S_WR_BODY: begin
        w_shift_en = 1'b1;
        if (!MDIO_OE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_wr_ld     = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end
      end
      S_RD_TA: begin
        if (r_cnt == c_CNT_TA_END) begin
          w_tx_ld     = 1'b1;
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_tx_clr    = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_tx_sh = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge MDC) begin
    if (RESET) begin
      r_shift   <= 16'd0;
      r_tx      <= 16'd0;
      MDIO_IN   <= 1'b0;
      ADDR      <= 5'd0;
      WR_DATA   <= 16'd0;
      WR_STB    <= 1'b0;
      MDIO_DONE <= 1'b0;
    end else begin
      WR_STB    <= w_wr_ld;
      MDIO_DONE <= w_done;
      if (w_shift_en) r_shift <= {r_shift[14:0], w_bit};
      if (w_addr_ld)  ADDR    <= {r_shift[3:0], w_bit};
      if (w_wr_ld)    WR_DATA <= {r_shift[14:0], w_bit};
      if (w_tx_ld) begin
        r_tx    <= RD_DATA;
        MDIO_IN <= RD_DATA[15];
      end else if (w_tx_sh) begin
        r_tx    <= {r_tx[14:0], 1'b0};
        MDIO_IN <= r_tx[14];
      end else if (w_tx_clr) begin
        MDIO_IN <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_receptor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_receptor
//  Brief    : Directed self-checking bench for mdio_receptor.
//  Revision : 1.0
// ============================================================================
module tb_mdio_receptor;

  logic        MDC = 1'b0;
  logic        RESET;
  logic [31:0] MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        MDIO_DONE;

  mdio_receptor dut (
    .MDC       (MDC),
    .RESET     (RESET),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .RD_DATA   (RD_DATA),
    .MDIO_IN   (MDIO_IN),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .WR_STB    (WR_STB),
    .MDIO_DONE (MDIO_DONE)
  );

  always #5 MDC = ~MDC;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stb_cnt  = 0;
  int done_cnt = 0;
  int done_cyc[$];

  always @(posedge MDC) cyc <= cyc + 1;

  // Pulse widths are measured by counting high levels at the falling edge.
  always @(negedge MDC) begin
    if (WR_STB === 1'b1) stb_cnt++;
    if (MDIO_DONE === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one line bit, then advance past the next rising edge.
  task automatic drive(input logic oe, input logic b);
    logic [31:0] rnd;
    rnd      = $urandom();
    MDIO_OE  = oe;
    MDIO_OUT = {rnd[31:1], b};
    @(posedge MDC);
    #1;
  endtask

  task automatic write_frame(input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] data);
    logic [31:0] f;
    f = {2'b01, 2'b01, phy, regad, 2'b10, data};
    for (int i = 31; i >= 0; i--) drive(1'b1, f[i]);
  endtask

  task automatic read_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                            output logic [4:0] addr14, output logic [15:0] rx);
    logic [13:0] h;
    logic [31:0] rnd;
    h = {2'b01, 2'b10, phy, regad};
    for (int i = 0; i < pre; i++) drive(1'b1, 1'b1);
    for (int i = 13; i >= 0; i--) drive(1'b1, h[i]);
    addr14 = ADDR;
    rx     = 16'd0;
    for (int e = 15; e <= 32; e++) begin
      if (e >= 17) rx[32 - e] = MDIO_IN;
      rnd = $urandom();
      drive(1'b0, rnd[0]);
    end
  endtask

  initial begin
    int          s0, d0, n0, gap;
    logic [4:0]  a;
    logic [15:0] rx;
    logic [31:0] f;
    logic [31:0] rnd;

    RESET    = 1'b1;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 32'd0;
    RD_DATA  = 16'd0;
    for (int i = 0; i < 2; i++) begin
      rnd = $urandom();
      drive(rnd[1], rnd[0]);
    end
    check("rst_mdio_in", MDIO_IN, 0);
    check("rst_addr", ADDR, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_wr_stb", WR_STB, 0);
    check("rst_done", MDIO_DONE, 0);
    RESET = 1'b0;

    // Plain write
    s0 = stb_cnt; d0 = done_cnt;
    write_frame(5'd1, 5'd5, 16'hBEEF);
    check("wr_addr", ADDR, 5);
    check("wr_data", WR_DATA, 16'hBEEF);
    check("wr_stb", WR_STB, 1);
    check("wr_done", MDIO_DONE, 1);
    drive(1'b0, 1'b1);
    check("wr_stb_fall", WR_STB, 0);
    check("wr_done_fall", MDIO_DONE, 0);
    check("wr_stb_count", stb_cnt - s0, 1);
    check("wr_done_count", done_cnt - d0, 1);

    // Read with preamble, controller releases line after header
    RD_DATA = 16'hA5C3;
    s0 = stb_cnt; d0 = done_cnt;
    read_frame(32, 5'd3, 5'd10, a, rx);
    check("rd_addr", a, 10);
    check("rd_bits", rx, 16'hA5C3);
    check("rd_done", MDIO_DONE, 1);
    check("rd_mdio_in_end", MDIO_IN, 0);
    drive(1'b0, 1'b1);
    check("rd_stb_count", stb_cnt - s0, 0);
    check("rd_done_count", done_cnt - d0, 1);

    // Invalid ST (00) then a valid write right behind it
    s0 = stb_cnt; d0 = done_cnt;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    write_frame(5'd2, 5'd7, 16'h1234);
    check("bad_st_addr", ADDR, 7);
    check("bad_st_data", WR_DATA, 16'h1234);
    drive(1'b0, 1'b1);
    check("bad_st_stb_count", stb_cnt - s0, 1);
    check("bad_st_done_count", done_cnt - d0, 1);

    // Invalid OP (11) then a valid write
    s0 = stb_cnt; d0 = done_cnt;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    write_frame(5'd0, 5'd18, 16'h5A5A);
    check("bad_op_addr", ADDR, 18);
    check("bad_op_data", WR_DATA, 16'h5A5A);
    drive(1'b0, 1'b1);
    check("bad_op_stb_count", stb_cnt - s0, 1);
    check("bad_op_done_count", done_cnt - d0, 1);

    // Reset on edge 20 of a write
    s0 = stb_cnt; d0 = done_cnt;
    f = {2'b01, 2'b01, 5'd0, 5'd4, 2'b10, 16'hCAFE};
    for (int i = 31; i > 12; i--) drive(1'b1, f[i]);
    RESET = 1'b1;
    drive(1'b1, f[12]);
    RESET = 1'b0;
    check("mid_rst_addr", ADDR, 0);
    check("mid_rst_data", WR_DATA, 0);
    check("mid_rst_stb", WR_STB, 0);
    check("mid_rst_done", MDIO_DONE, 0);
    check("mid_rst_mdio_in", MDIO_IN, 0);
    write_frame(5'd0, 5'd31, 16'h0001);
    check("post_rst_addr", ADDR, 31);
    check("post_rst_data", WR_DATA, 16'h0001);
    drive(1'b0, 1'b1);
    check("post_rst_stb_count", stb_cnt - s0, 1);

    // Back-to-back write then read
    RD_DATA = 16'h0F0F;
    n0 = done_cyc.size();
    s0 = stb_cnt;
    write_frame(5'd5, 5'd3, 16'h1357);
    check("b2b_wr_addr", ADDR, 3);
    check("b2b_wr_data", WR_DATA, 16'h1357);
    check("b2b_wr_stb", WR_STB, 1);
    read_frame(0, 5'd5, 5'd9, a, rx);
    check("b2b_rd_addr", a, 9);
    check("b2b_rd_bits", rx, 16'h0F0F);
    check("b2b_rd_done", MDIO_DONE, 1);
    check("b2b_rd_wr_data_held", WR_DATA, 16'h1357);
    drive(1'b0, 1'b1);
    check("b2b_stb_count", stb_cnt - s0, 1);
    check("b2b_done_count", done_cyc.size() - n0, 2);
    gap = (done_cyc.size() >= n0 + 2) ? done_cyc[n0 + 1] - done_cyc[n0] : -1;
    check("b2b_done_gap", gap, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_receptor.md
# mdio_receptor

Serial MDIO management-frame receiver (PHY/slave side, IEEE 802.3 Clause 22 framing) clocked by MDC. Decodes write and read frames arriving on the management data line. Write frames produce a register-write strobe with address and data. Read frames cause the block to fetch `RD_DATA` and shift it back to the controller on `MDIO_IN`. It sits between the MDIO controller (generator) and the PHY register file.

## Interface
- No parameters.
- `MDC` in 1: management clock; all logic on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `MDIO_OUT` in 32: line from the controller.
  - Only bit 0 carries serial frame data, MSB of frame first.
  - Bits 31:1 are ignored.
- `MDIO_OE` in 1: controller is driving the line; `MDIO_OUT[0]` is valid only when 1.
- `RD_DATA` in 16: register read value from the register file.
- `MDIO_IN` out 1: serial read data to the controller.
- `ADDR` out 5: register address (REGAD field).
- `WR_DATA` out 16: write data.
- `WR_STB` out 1: one-cycle write strobe.
- `MDIO_DONE` out 1: one-cycle pulse at the end of every completed frame.

## Operation
- **Frame layout (32 bits, MSB first):**
  - ST = 01
  - OP = 01 (write) or 10 (read)
  - PHYAD[4:0], accepted for any value and ignored
  - REGAD[4:0]
  - TA = 2 bits
  - DATA[15:0]
- **States:** IDLE, HEADER, WR_BODY, RD_TA, RD_DATA.
- **IDLE:**
  - Sampled 1s are treated as preamble and ignored. Cycles with `MDIO_OE`=0 are also ignored.
  - The first rising edge with `MDIO_OE`=1 and `MDIO_OUT[0]`=0 is frame edge 1 (first ST bit).
  - Go to HEADER; edge counter = 1.
- **HEADER (edges 2..14):** shift in one bit per edge.
  - Edge 2: bit ≠1 (invalid ST) → IDLE.
  - Edge 4: OP ∈ {00, 11} → IDLE.
  - Edge 14: `ADDR` ← REGAD (registered). Then go to WR_BODY if OP=01, or RD_TA if OP=10.
  - `MDIO_OE`=0 at any header edge → IDLE, outputs unchanged.
- **WR_BODY (edges 15..32):** sample TA and 16 data bits.
  - `MDIO_OE`=0 on any edge → abort to IDLE with no strobe.
  - Edge 32: `WR_DATA` ← DATA, `WR_STB`=1 and `MDIO_DONE`=1 for one cycle, then IDLE.
- **RD_TA (edges 15..16):** line is ignored.
  - Edge 16: latch `RD_DATA` into the transmit shift register.
  - `MDIO_IN` ← `RD_DATA[15]`.
- **RD_DATA (edges 17..32):**
  - Edges 17..31: shift left, so `MDIO_IN` presents bits 14..0 in turn.
  - Edge 32: `MDIO_IN` ← 0, `MDIO_DONE`=1 for one cycle, then IDLE.
  - `MDIO_OE` is not checked in this state.
- `ADDR` and `WR_DATA` hold their last values until overwritten.
- A new frame may begin on the edge immediately after edge 32 (back-to-back frames).

## Timing
- **Reset:** `RESET`=1 at a rising edge forces:
  - state IDLE, counter 0
  - `MDIO_IN`=0, `ADDR`=0, `WR_DATA`=0, `WR_STB`=0, `MDIO_DONE`=0
  - This applies mid-frame; the partial frame is discarded with no strobe.
- All outputs are registered and change only on rising `MDC`.
- **Write:** `WR_STB`/`MDIO_DONE` are high during the cycle after edge 32, with `ADDR`/`WR_DATA` valid in the same cycle.
- **Read:**
  - `ADDR` is valid from edge 14.
  - `RD_DATA` must be stable by edge 16, i.e. 2 cycles of address-to-data latency.
  - The controller samples `MDIO_IN` on edges 17..32: `RD_DATA[15]` first, `RD_DATA[0]` last.
- `WR_STB` is never asserted for read or aborted frames.

## Test plan
- **Reset:** hold `RESET`=1 for 2 edges with random line activity → all outputs 0; then release → state IDLE.
- **Write:** frame 01 01 00001 00101 10 0xBEEF with `MDIO_OE`=1 for 32 edges → after edge 32, `ADDR`=5, `WR_DATA`=0xBEEF, `WR_STB`=`MDIO_DONE`=1 for exactly one cycle.
- **Read:**
  - Stimulus: 32 preamble 1s, then header 01 10 00011 01010 with `MDIO_OE`=1 for 14 edges, then `MDIO_OE`=0 for 18 edges; `RD_DATA`=0xA5C3.
  - Required: `ADDR`=10 after edge 14; `MDIO_IN` sampled on edges 17..32 = 1010010111000011; `MDIO_DONE` pulse; `WR_STB` stays 0.
- **Invalid ST/OP:** start 00… → returns to IDLE at edge 2; OP=11 → IDLE at edge 4. In both cases no `WR_STB`/`MDIO_DONE`, and a following valid write is decoded correctly.
- **Reset mid-frame:** `RESET`=1 at edge 20 of a write → no `WR_STB`, outputs 0; a subsequent write to `ADDR`=31 with data 0x0001 succeeds.
- **Back-to-back:** a write followed immediately by a read, with no idle edges → both decode, with two `MDIO_DONE` pulses 32 cycles apart.
